// File: rtl/inst_prefetch_if.sv
// Wishbone B4 classic instruction-fetch bus between inst_prefetch (master) and memory (slave).
interface inst_prefetch_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetcher: Wishbone reads into a {pc, inst, err} FIFO for decode.
// Define INST_PREFETCH_STATS_EN to add the fetch_cnt_o / flush_cnt_o event counters.
module inst_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_err_o,
  input  logic        inst_ready_i,
`ifdef INST_PREFETCH_STATS_EN
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  inst_prefetch_if.master wb
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StDiscard, StHalt} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     adr_q, adr_d;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [31:0]     pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic            err_mem  [DEPTH];

  logic            push, push_err, pop;
  logic [31:0]     push_inst;
  logic            unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc_i[1:0];

  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_mem[rd_ptr_q];
  assign inst_pc_o    = pc_mem[rd_ptr_q];
  assign inst_err_o   = err_mem[rd_ptr_q];

  // A redirect cycle never consumes the head; the FIFO is being cleared anyway.
  assign pop = inst_valid_o && inst_ready_i && !redirect_i;

  assign wb.wb_cyc_o = (state_q == StReq) || (state_q == StDiscard);
  assign wb.wb_stb_o = (state_q == StReq) || (state_q == StDiscard);
  assign wb.wb_we_o  = 1'b0;
  assign wb.wb_sel_o = 4'hF;
  assign wb.wb_adr_o = adr_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    adr_d      = adr_q;
    push       = 1'b0;
    push_err   = 1'b0;
    push_inst  = wb.wb_dat_i;

    unique case (state_q)
      StIdle: begin
        // Reserve a slot before issuing so the eventual push can never overflow.
        if (!redirect_i && ((count_q < CW'(DEPTH)) || pop)) begin
          state_d = StReq;
          adr_d   = fetch_pc_q;
        end
      end
      StReq: begin
        if (wb.wb_ack_i) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = StIdle;
        end else if (wb.wb_err_i) begin
          push      = 1'b1;
          push_err  = 1'b1;
          push_inst = 32'h0000_0013;
          state_d   = StHalt;
        end
      end
      StDiscard: begin
        if (wb.wb_ack_i || wb.wb_err_i) begin
          state_d = StIdle;
        end
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase

    if (redirect_i) begin
      push       = 1'b0;
      push_err   = 1'b0;
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      if (((state_q == StReq) || (state_q == StDiscard)) && !wb.wb_ack_i && !wb.wb_err_i) begin
        state_d = StDiscard;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      adr_q      <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
        err_mem[i]  <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      adr_q      <= adr_d;
      if (redirect_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr_q]   <= fetch_pc_q;
          inst_mem[wr_ptr_q] <= push_inst;
          err_mem[wr_ptr_q]  <= push_err;
          wr_ptr_q           <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef INST_PREFETCH_STATS_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (push && !push_err) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect_i)        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Scoreboard bench for inst_prefetch against a configurable-latency Wishbone memory model.
module tb_inst_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ready = 1'b0;
  logic        inst_valid, inst_err;
  logic [31:0] inst, inst_pc;
`ifdef INST_PREFETCH_STATS_EN
  logic [31:0] fetch_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  inst_prefetch_if wb();

  inst_prefetch #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .inst_valid_o  (inst_valid),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_err_o    (inst_err),
    .inst_ready_i  (ready),
`ifdef INST_PREFETCH_STATS_EN
    .fetch_cnt_o   (fetch_cnt),
    .flush_cnt_o   (flush_cnt),
`endif
    .wb            (wb)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [64:0] exp_q[$];

  // Memory image: word i is "addi x(i+1), x0, i" -> 0x00000093, 0x00100113, ...
  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] w1;
    w  = a >> 2;
    w1 = w + 32'd1;
    return ({20'h0, w[11:0]} << 20) | ({27'h0, w1[4:0]} << 7) | 32'h13;
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Wishbone slave: acks (or errors) after 'lat' wait cycles of a held strobe.
  int unsigned lat = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_adr = 32'h0;
  int unsigned wcnt = 0;
  logic        hit;

  assign hit         = wb.wb_cyc_o && wb.wb_stb_o && (wcnt == lat);
  assign wb.wb_err_i = hit && err_en && (wb.wb_adr_o == err_adr);
  assign wb.wb_ack_i = hit && !wb.wb_err_i;
  assign wb.wb_dat_i = memword(wb.wb_adr_o);

  int unsigned n_ack = 0;
  int unsigned cyc_cnt = 0;
  int unsigned cycle = 0;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (wb.wb_cyc_o) cyc_cnt <= cyc_cnt + 1;
    if (rst || !(wb.wb_cyc_o && wb.wb_stb_o) || wb.wb_ack_i || wb.wb_err_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (rst) n_ack <= 0;
    else if (wb.wb_ack_i) n_ack <= n_ack + 1;
  end

  // Monitor: every accepted head is popped from the scoreboard and compared.
  logic        gap_chk = 1'b0;
  logic        have_last = 1'b0;
  int unsigned last_pop = 0;

  always @(negedge clk) begin
    if (!rst && inst_valid && ready && !redirect) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h inst %h err %b, expected no entry",
                 inst_pc, inst, inst_err);
      end else begin
        check("pop {pc,inst,err}", {inst_pc, inst, inst_err}, exp_q.pop_front());
      end
      if (gap_chk) begin
        if (have_last) check("pop_gap", 65'(cycle - last_pop), 65'd2);
        have_last = 1'b1;
        last_pop  = cycle;
      end
    end
    if (!gap_chk) have_last = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ready    = 1'b0;
    redirect = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] pc;
      pc = start + 32'(4 * i);
      exp_q.push_back({pc, memword(pc), 1'b0});
    end
  endtask

  task automatic wait_empty(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      tick();
      k++;
    end
    ready = 1'b0;
    check({"drain_", name}, 65'(exp_q.size()), 65'd0);
    exp_q.delete();
  endtask

  task automatic wait_acks(input int unsigned n);
    int k = 0;
    while (n_ack < n && k < 200) begin
      tick();
      k++;
    end
    check("wait_acks", 65'(n_ack >= n), 65'd1);
  endtask

  task automatic wait_cyc();
    int k = 0;
    while (!wb.wb_cyc_o && k < 200) begin
      tick();
      k++;
    end
    check("wait_cyc", 65'(wb.wb_cyc_o), 65'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    int unsigned snap;

    // Reset values, then streaming with ready held high.
    lat = 0;
    do_reset();
    check("rst_cyc", 65'(wb.wb_cyc_o), 65'd0);
    check("rst_stb", 65'(wb.wb_stb_o), 65'd0);
    check("rst_adr", 65'(wb.wb_adr_o), 65'h0);
    check("rst_valid", 65'(inst_valid), 65'd0);
    check("rst_head", {inst_pc, inst, inst_err}, 65'h0);
    check("const_we_sel", 65'({wb.wb_we_o, wb.wb_sel_o}), 65'h0F);
    expect_seq(32'h0, 8);
    gap_chk = 1'b1;
    ready   = 1'b1;
    rst     = 1'b0;
    wait_empty("stream");
    gap_chk = 1'b0;

    // Backpressure: four reads fill the FIFO, then the bus goes quiet.
    do_reset();
    rst = 1'b0;
    repeat (40) tick();
    check("full_acks", 65'(n_ack), 65'd4);
    check("full_cyc", 65'(wb.wb_cyc_o), 65'd0);
    check("full_valid", 65'(inst_valid), 65'd1);
`ifdef INST_PREFETCH_STATS_EN
    check("stats_fetch", 65'(fetch_cnt), 65'd4);
    check("stats_flush0", 65'(flush_cnt), 65'd0);
`endif
    expect_seq(32'h0, 6);
    ready = 1'b1;
    wait_empty("backpressure");

    // Redirect while a slow read is outstanding: stale response discarded.
    lat = 3;
    do_reset();
    rst = 1'b0;
    wait_acks(2);
    wait_cyc();
    tick();
    check("pre_redir_valid", 65'(inst_valid), 65'd1);
    do_redirect(32'h0000_0102);
    check("discard_valid", 65'(inst_valid), 65'd0);
    check("discard_cyc", 65'(wb.wb_cyc_o), 65'd1);
    check("discard_adr", 65'(wb.wb_adr_o), 65'h8);
    expect_seq(32'h0000_0100, 3);
    ready = 1'b1;
    wait_empty("redirect_outstanding");
`ifdef INST_PREFETCH_STATS_EN
    check("stats_flush1", 65'(flush_cnt), 65'd1);
`endif

    // Redirect in the same cycle as an ack: the acked word never appears.
    lat = 0;
    do_reset();
    rst = 1'b0;
    wait_acks(2);
    wait_cyc();
    check("same_cycle_ack", 65'(wb.wb_ack_i), 65'd1);
    do_redirect(32'h0000_0200);
    check("ack_redir_valid", 65'(inst_valid), 65'd0);
    check("ack_redir_cyc", 65'(wb.wb_cyc_o), 65'd0);
    expect_seq(32'h0000_0200, 2);
    ready = 1'b1;
    wait_empty("redirect_ack");

    // Bus error at 0x20: error entry delivered, then the bus halts until redirect.
    do_reset();
    err_en  = 1'b1;
    err_adr = 32'h0000_0020;
    expect_seq(32'h0, 8);
    exp_q.push_back({32'h0000_0020, 32'h0000_0013, 1'b1});
    ready = 1'b1;
    rst   = 1'b0;
    wait_empty("bus_error");
    snap = cyc_cnt;
    repeat (10) tick();
    check("halt_no_cyc", 65'(cyc_cnt - snap), 65'd0);
    check("halt_valid", 65'(inst_valid), 65'd0);
    err_en = 1'b0;
    expect_seq(32'h0, 2);
    do_redirect(32'h0);
    ready = 1'b1;
    wait_empty("resume");

    // Address wrap past 0xFFFF_FFFC.
    expect_seq(32'hFFFF_FFF8, 4);
    do_redirect(32'hFFFF_FFF8);
    ready = 1'b1;
    wait_empty("wrap");
`ifdef INST_PREFETCH_STATS_EN
    check("stats_flush2", 65'(flush_cnt), 65'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
